// File: rtl/alu_3bit_issue.sv
// Issue/writeback stage around an external 3-bit combinational ALU: latches operands from a
// small register file, captures the ALU result and flags, writes back, and hands off downstream.
module alu_3bit_issue #(
    parameter int NREGS  = 4,
    parameter bit WB_CMP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [1:0] in_dst,
    input  logic [1:0] in_src_a,
    input  logic [1:0] in_src_b,
    input  logic       in_imm_en,
    input  logic [2:0] in_imm,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [2:0] alu_result,
    input  logic [4:0] alu_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_result,
    output logic [4:0] out_flags,
    output logic [1:0] dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid/ready are decoded from the registered state, so they never glitch.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int AW = (NREGS == 2) ? 1 : 2;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] dst_q, dst_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [2:0] res_q, res_d;
    logic [4:0] flags_q, flags_d;
    logic [2:0] rf_q [NREGS];
    logic [2:0] rf_d [NREGS];
    logic       cmp_flag;

    // Compare ops 101/110/111 pick equal/less_than/greater_than from the captured flags.
    always_comb begin
        cmp_flag = flags_q[0];
        case (op_q)
            3'b101:  cmp_flag = flags_q[2];
            3'b110:  cmp_flag = flags_q[1];
            default: cmp_flag = flags_q[0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        flags_d   = flags_q;
        rf_d      = rf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = in_op;
                    dst_d   = in_dst;
                    a_d     = rf_q[in_src_a[AW-1:0]];
                    b_d     = in_imm_en ? in_imm : rf_q[in_src_b[AW-1:0]];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_result;
                flags_d = alu_flags;
                state_d = S_WB;
            end
            S_WB: begin
                out_valid = 1'b1;
                if (op_q <= 3'b100) begin
                    rf_d[dst_q[AW-1:0]] = res_q;
                end else if (WB_CMP) begin
                    rf_d[dst_q[AW-1:0]] = {2'b00, cmp_flag};
                end
                state_d = out_ready ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rf_q    <= rf_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = op_q;
    assign out_result = res_q;
    assign out_flags  = flags_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_3bit_issue.sv
// Directed bench for alu_3bit_issue with a behavioural 3-bit ALU closing the loop.
module tb_alu_3bit_issue;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_dst;
    logic [1:0] in_src_a;
    logic [1:0] in_src_b;
    logic       in_imm_en;
    logic [2:0] in_imm;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [2:0] alu_sel;
    logic [2:0] alu_result;
    logic [4:0] alu_flags;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_result;
    logic [4:0] out_flags;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    alu_3bit_issue #(.NREGS(4), .WB_CMP(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_dst     (in_dst),
        .in_src_a   (in_src_a),
        .in_src_b   (in_src_b),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: compares return {2'b00,flag}; SUB carry is the borrow.
    logic [3:0] sum;
    logic       carry;
    always_comb begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        carry      = 1'b0;
        alu_result = 3'b000;
        case (alu_sel)
            3'b000: alu_result = alu_a ^ alu_b;
            3'b001: begin alu_result = sum[2:0]; carry = sum[3]; end
            3'b010: begin alu_result = alu_a - alu_b; carry = (alu_a < alu_b); end
            3'b011: alu_result = alu_a & alu_b;
            3'b100: alu_result = alu_a | alu_b;
            3'b101: alu_result = {2'b00, alu_a == alu_b};
            3'b110: alu_result = {2'b00, alu_a < alu_b};
            default: alu_result = {2'b00, alu_a > alu_b};
        endcase
        alu_flags = {carry, alu_result == 3'b000, alu_a == alu_b, alu_a < alu_b, alu_a > alu_b};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: called #1 after a rising edge with the stage idle; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ie, input logic [2:0] imm);
        chk("in_ready_before_issue", {7'd0, in_ready}, 8'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_dst    = dst;
        in_src_a  = sa;
        in_src_b  = sb;
        in_imm_en = ie;
        in_imm    = imm;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_op     = $urandom_range(0, 7);
        in_dst    = $urandom_range(0, 3);
        in_src_a  = $urandom_range(0, 3);
        in_src_b  = $urandom_range(0, 3);
        in_imm    = $urandom_range(0, 7);
    endtask

    // Full transaction with out_ready high; checks latency, result and flags.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb, input logic ie,
                          input logic [2:0] imm, input logic [2:0] exp_res, input logic [4:0] exp_flg);
        out_ready = 1'b1;
        issue(op, dst, sa, sb, ie, imm);
        chk({tag, "_exec_out_valid"}, {7'd0, out_valid}, 8'd0);
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, {7'd0, out_valid}, 8'd1);
        chk({tag, "_result"}, {5'd0, out_result}, {5'd0, exp_res});
        chk({tag, "_flags"}, {3'd0, out_flags}, {3'd0, exp_flg});
        @(posedge clk);
        #1;
    endtask

    // Read a register back with OR rX=rX|rX, which leaves it unchanged.
    task automatic read_reg(input string tag, input logic [1:0] r, input logic [2:0] exp_val);
        run_op(tag, 3'b100, r, r, r, 1'b0, 3'd0, exp_val,
               {1'b0, exp_val == 3'd0, 1'b1, 1'b0, 1'b0});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_dst    = '0;
        in_src_a  = '0;
        in_src_b  = '0;
        in_imm_en = 1'b0;
        in_imm    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_result", {5'd0, out_result}, 8'd0);
        chk("rst_out_flags", {3'd0, out_flags}, 8'd0);
        chk("rst_alu_ops", {alu_sel, alu_b, 2'b00}, 8'd0);
        chk("rst_alu_a", {5'd0, alu_a}, 8'd0);
        read_reg("rd_r0", 2'd0, 3'd0);
        read_reg("rd_r1", 2'd1, 3'd0);
        read_reg("rd_r2", 2'd2, 3'd0);
        read_reg("rd_r3", 2'd3, 3'd0);

        // ADD with immediate, wrap modulo 8
        run_op("add_r1_r0_7", 3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 3'd7, 3'd7, 5'b00010);
        run_op("add_r2_r1_1", 3'b001, 2'd2, 2'd1, 2'd0, 1'b1, 3'd1, 3'd0, 5'b11001);
        read_reg("rd_r2_wrap", 2'd2, 3'd0);
        read_reg("rd_r1_7", 2'd1, 3'd7);

        // SUB with src == dst
        run_op("xor_r1_5", 3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 3'd5, 3'd5, 5'b00010);
        run_op("sub_r1_r1", 3'b010, 2'd1, 2'd1, 2'd1, 1'b0, 3'd0, 3'd0, 5'b01100);
        read_reg("rd_r1_sub", 2'd1, 3'd0);

        // Compare never writes back when WB_CMP=0
        run_op("set_r1_1", 3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 3'd1, 3'd1, 5'b00010);
        run_op("set_r2_6", 3'b001, 2'd2, 2'd0, 2'd0, 1'b1, 3'd6, 3'd6, 5'b00010);
        run_op("set_r3_3", 3'b001, 2'd3, 2'd0, 2'd0, 1'b1, 3'd3, 3'd3, 5'b00010);
        run_op("lt_r3", 3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 3'd0, 3'd1, 5'b00010);
        read_reg("rd_r3_kept", 2'd3, 3'd3);

        // Backpressure: ADD r2=r1+2 held for 4 cycles
        out_ready = 1'b0;
        issue(3'b001, 2'd2, 2'd1, 2'd0, 1'b1, 3'd2);
        chk("bp_alu_a", {5'd0, alu_a}, 8'd1);
        chk("bp_alu_b", {5'd0, alu_b}, 8'd2);
        chk("bp_alu_sel", {5'd0, alu_sel}, 8'd1);
        chk("bp_exec_in_ready", {7'd0, in_ready}, 8'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_dst   = 2'd2;
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", {7'd0, out_valid}, 8'd1);
            chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
            chk("bp_result", {5'd0, out_result}, 8'd3);
            chk("bp_flags", {3'd0, out_flags}, 8'b00010);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_release_valid", {7'd0, out_valid}, 8'd1);
        @(posedge clk);
        #1;
        chk("bp_done_out_valid", {7'd0, out_valid}, 8'd0);
        read_reg("rd_r2_bp", 2'd2, 3'd3);
        read_reg("rd_r1_bp", 2'd1, 3'd1);

        // Reset while EXEC
        issue(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 3'd5);
        chk("mid_exec_in_ready", {7'd0, in_ready}, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst2_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst2_out_result", {5'd0, out_result}, 8'd0);
        chk("rst2_out_flags", {3'd0, out_flags}, 8'd0);
        chk("rst2_alu_a", {5'd0, alu_a}, 8'd0);
        @(posedge clk);
        #1;
        chk("rst2_out_valid_later", {7'd0, out_valid}, 8'd0);
        read_reg("rd_r1_rst", 2'd1, 3'd0);
        read_reg("rd_r2_rst", 2'd2, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
